kp_topk_select: RTL and testbench

KP_TOPK_SELECT -- requirements
Module: kp_topk_select

---
 rtl/kp_topk_select_pkg.sv | 19 +
 rtl/kp_sort_cell.sv | 94 +++++++++
 rtl/kp_topk_select.sv | 172 +++++++++++++++++
 tb/tb_kp_topk_select.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/kp_topk_select_pkg.sv
// Shared definitions for the top-K keypoint selector: default widths,
// controller state encoding and the constants describing an empty-frame beat.
package kp_topk_select_pkg;

  localparam int DEF_COOR_W  = 10;
  localparam int DEF_SCORE_W = 8;
  localparam int DEF_DESC_W  = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } kp_state_e;

  localparam logic EMPTY_START = 1'b1;
  localparam logic EMPTY_END   = 1'b1;
  localparam logic EMPTY_FLAG  = 1'b0;

endpackage

// File: rtl/kp_sort_cell.sv
// One slot of the descending-score insertion table. Each slot either holds,
// takes the new keypoint, takes its upper neighbour (shift down on insert)
// or takes its lower neighbour (shift up on drain).
module kp_sort_cell #(
  parameter int COOR_W  = 10,
  parameter int SCORE_W = 8,
  parameter int DESC_W  = 256
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_head,
  input  logic               i_clear,
  input  logic               i_ins,
  input  logic               i_pop,
  input  logic [SCORE_W-1:0] i_new_score,
  input  logic [COOR_W-1:0]  i_new_x,
  input  logic [COOR_W-1:0]  i_new_y,
  input  logic [DESC_W-1:0]  i_new_desc,
  input  logic               i_prev_keep,
  input  logic               i_prev_valid,
  input  logic [SCORE_W-1:0] i_prev_score,
  input  logic [COOR_W-1:0]  i_prev_x,
  input  logic [COOR_W-1:0]  i_prev_y,
  input  logic [DESC_W-1:0]  i_prev_desc,
  input  logic               i_next_valid,
  input  logic [SCORE_W-1:0] i_next_score,
  input  logic [COOR_W-1:0]  i_next_x,
  input  logic [COOR_W-1:0]  i_next_y,
  input  logic [DESC_W-1:0]  i_next_desc,
  output logic               o_keep,
  output logic               o_valid,
  output logic [SCORE_W-1:0] o_score,
  output logic [COOR_W-1:0]  o_x,
  output logic [COOR_W-1:0]  o_y,
  output logic [DESC_W-1:0]  o_desc
);

  logic               valid_q;
  logic [SCORE_W-1:0] score_q;
  logic [COOR_W-1:0]  x_q;
  logic [COOR_W-1:0]  y_q;
  logic [DESC_W-1:0]  desc_q;
  logic               take_slot;
  logic               load_new;
  logic               load_prev;
  logic               load_next;

  // ">=" keeps an equal-score entry ahead of the newcomer, preserving arrival order
  assign o_keep    = valid_q && (score_q >= i_new_score);
  assign take_slot = i_ins && !o_keep;
  assign load_new  = i_clear ? (i_head && i_ins) : (!i_pop && take_slot && i_prev_keep);
  assign load_prev = !i_clear && !i_pop && take_slot && !i_prev_keep;
  assign load_next = !i_clear && i_pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
    end else if (i_clear) begin
      valid_q <= i_head && i_ins;
    end else if (load_next) begin
      valid_q <= i_next_valid;
    end else if (load_new) begin
      valid_q <= 1'b1;
    end else if (load_prev) begin
      valid_q <= i_prev_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (load_new) begin
      score_q <= i_new_score;
      x_q     <= i_new_x;
      y_q     <= i_new_y;
      desc_q  <= i_new_desc;
    end else if (load_prev) begin
      score_q <= i_prev_score;
      x_q     <= i_prev_x;
      y_q     <= i_prev_y;
      desc_q  <= i_prev_desc;
    end else if (load_next) begin
      score_q <= i_next_score;
      x_q     <= i_next_x;
      y_q     <= i_next_y;
      desc_q  <= i_next_desc;
    end
  end

  assign o_valid = valid_q;
  assign o_score = score_q;
  assign o_x     = x_q;
  assign o_y     = y_q;
  assign o_desc  = desc_q;

endmodule

// File: rtl/kp_topk_select.sv
// Keeps the K highest-scoring keypoints of a frame in a sorted cell chain and
// streams them out highest first after frame end, with a ready/valid handshake.
module kp_topk_select
  import kp_topk_select_pkg::*;
#(
  parameter int K       = 32,
  parameter int DESC_W  = DEF_DESC_W,
  parameter int COOR_W  = DEF_COOR_W,
  parameter int SCORE_W = DEF_SCORE_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_end,
  input  logic                   i_flag,
  input  logic [COOR_W-1:0]      i_coor_x,
  input  logic [COOR_W-1:0]      i_coor_y,
  input  logic [SCORE_W-1:0]     i_score,
  input  logic [DESC_W-1:0]      i_descriptor,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_start,
  output logic                   o_end,
  output logic                   o_flag,
  output logic [COOR_W-1:0]      o_coor_x,
  output logic [COOR_W-1:0]      o_coor_y,
  output logic [SCORE_W-1:0]     o_score,
  output logic [DESC_W-1:0]      o_descriptor,
  output logic                   o_busy,
  output logic                   o_frame_drop,
  output logic [$clog2(K+1)-1:0] o_count,
  output logic [15:0]            o_discarded
);

  localparam int CNT_W = $clog2(K+1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  kp_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, held_d;
  logic [15:0]        disc_q, disc_d;
  logic               vld_p0, start_p0, start_d, drop_p0;
  logic               start_ok, collecting, ins, hs, last_beat, clear, full;

  // Slot K is a permanently empty sentinel feeding the tail during drain
  logic [K:0]         tab_v;
  logic [K:0]         keep_c;
  logic [SCORE_W-1:0] tab_score [K+1];
  logic [COOR_W-1:0]  tab_x     [K+1];
  logic [COOR_W-1:0]  tab_y     [K+1];
  logic [DESC_W-1:0]  tab_desc  [K+1];

  assign start_ok   = i_start && (state_q != ST_DRAIN);
  assign collecting = (state_q == ST_COLLECT) || start_ok;
  assign ins        = i_flag && collecting;
  assign hs         = (state_q == ST_DRAIN) && i_ready;
  assign last_beat  = (cnt_q == CNT_W'(1));
  assign clear      = start_ok || (hs && last_beat);
  assign full       = tab_v[K-1];

  assign keep_c[0]    = 1'b1;
  assign tab_v[K]     = 1'b0;
  assign tab_score[K] = '0;
  assign tab_x[K]     = '0;
  assign tab_y[K]     = '0;
  assign tab_desc[K]  = '0;

  for (genvar i = 0; i < K; i++) begin : g_cell
    localparam int P = (i == 0) ? 0 : i - 1;
    kp_sort_cell #(
      .COOR_W (COOR_W),
      .SCORE_W(SCORE_W),
      .DESC_W (DESC_W)
    ) u_cell (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_head      (i == 0),
      .i_clear     (clear),
      .i_ins       (ins),
      .i_pop       (hs),
      .i_new_score (i_score),
      .i_new_x     (i_coor_x),
      .i_new_y     (i_coor_y),
      .i_new_desc  (i_descriptor),
      .i_prev_keep (keep_c[i]),
      .i_prev_valid(tab_v[P]),
      .i_prev_score(tab_score[P]),
      .i_prev_x    (tab_x[P]),
      .i_prev_y    (tab_y[P]),
      .i_prev_desc (tab_desc[P]),
      .i_next_valid(tab_v[i+1]),
      .i_next_score(tab_score[i+1]),
      .i_next_x    (tab_x[i+1]),
      .i_next_y    (tab_y[i+1]),
      .i_next_desc (tab_desc[i+1]),
      .o_keep      (keep_c[i+1]),
      .o_valid     (tab_v[i]),
      .o_score     (tab_score[i]),
      .o_x         (tab_x[i]),
      .o_y         (tab_y[i]),
      .o_desc      (tab_desc[i])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (i_start) state_d = ST_COLLECT;
      ST_COLLECT: if (i_end) state_d = ST_DRAIN;
      ST_DRAIN:   if (hs && last_beat) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    held_d = cnt_q;
    if (start_ok) held_d = ins ? CNT_W'(1) : '0;
    else if (ins && !full) held_d = cnt_q + CNT_W'(1);

    cnt_d = cnt_q;
    if (state_q == ST_DRAIN) begin
      if (hs) cnt_d = cnt_q - CNT_W'(1);
    end else if (collecting) begin
      // An empty frame still owes one beat downstream
      if (state_d == ST_DRAIN) cnt_d = (held_d == '0) ? CNT_W'(1) : held_d;
      else cnt_d = held_d;
    end

    disc_d = disc_q;
    if (start_ok) disc_d = '0;
    else if (ins && full) disc_d = sat_inc16(disc_q);

    start_d = start_p0;
    if ((state_q != ST_DRAIN) && (state_d == ST_DRAIN)) start_d = 1'b1;
    else if (hs) start_d = 1'b0;
  end

  // Stage p0: registered output framing, driven only from state, never from i_ready
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      disc_q   <= '0;
      vld_p0   <= 1'b0;
      start_p0 <= 1'b0;
      drop_p0  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      disc_q   <= disc_d;
      vld_p0   <= (state_d == ST_DRAIN);
      start_p0 <= start_d;
      drop_p0  <= i_start && (state_q == ST_DRAIN);
    end
  end

  assign o_valid      = vld_p0;
  assign o_busy       = vld_p0;
  assign o_start      = vld_p0 && (tab_v[0] ? start_p0 : (start_p0 && EMPTY_START));
  assign o_end        = vld_p0 && (tab_v[0] ? last_beat : EMPTY_END);
  assign o_flag       = vld_p0 && (tab_v[0] ? 1'b1 : EMPTY_FLAG);
  assign o_score      = o_flag ? tab_score[0] : '0;
  assign o_coor_x     = o_flag ? tab_x[0] : '0;
  assign o_coor_y     = o_flag ? tab_y[0] : '0;
  assign o_descriptor = o_flag ? tab_desc[0] : '0;
  assign o_frame_drop = drop_p0;
  assign o_count      = cnt_q;
  assign o_discarded  = disc_q;

endmodule

// File: tb/tb_kp_topk_select.sv
// Directed bench for kp_topk_select with K=4: ordering, ties, eviction,
// empty frame, back-pressure, dropped start and mid-frame reset.
module tb_kp_topk_select;

  localparam int K       = 4;
  localparam int DESC_W  = 16;
  localparam int COOR_W  = 10;
  localparam int SCORE_W = 8;
  localparam int CNT_W   = $clog2(K+1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_start, i_end, i_flag, i_ready;
  logic [COOR_W-1:0]  i_coor_x, i_coor_y;
  logic [SCORE_W-1:0] i_score;
  logic [DESC_W-1:0]  i_descriptor;
  logic               o_valid, o_start, o_end, o_flag, o_busy, o_frame_drop;
  logic [COOR_W-1:0]  o_coor_x, o_coor_y;
  logic [SCORE_W-1:0] o_score;
  logic [DESC_W-1:0]  o_descriptor;
  logic [CNT_W-1:0]   o_count;
  logic [15:0]        o_discarded;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kp_topk_select #(
    .K(K), .DESC_W(DESC_W), .COOR_W(COOR_W), .SCORE_W(SCORE_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_end(i_end), .i_flag(i_flag),
    .i_coor_x(i_coor_x), .i_coor_y(i_coor_y), .i_score(i_score), .i_descriptor(i_descriptor),
    .o_valid(o_valid), .i_ready(i_ready), .o_start(o_start), .o_end(o_end), .o_flag(o_flag),
    .o_coor_x(o_coor_x), .o_coor_y(o_coor_y), .o_score(o_score), .o_descriptor(o_descriptor),
    .o_busy(o_busy), .o_frame_drop(o_frame_drop), .o_count(o_count), .o_discarded(o_discarded)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    i_start = 1'b0; i_end = 1'b0; i_flag = 1'b0;
    i_score = '0; i_coor_x = '0; i_coor_y = '0; i_descriptor = '0;
  endtask

  function automatic logic [COOR_W-1:0] y_of(input logic [COOR_W-1:0] x);
    return x + 10'd100;
  endfunction

  function automatic logic [DESC_W-1:0] d_of(input logic [COOR_W-1:0] x);
    return {6'd0, x} ^ 16'hA5A5;
  endfunction

  task automatic beat(input logic s, input logic e, input logic f,
                      input logic [SCORE_W-1:0] sc, input logic [COOR_W-1:0] x);
    i_start = s; i_end = e; i_flag = f; i_score = sc;
    i_coor_x = x; i_coor_y = y_of(x); i_descriptor = d_of(x);
    tick();
    clr_in();
  endtask

  task automatic expect_beat(input string tag, input logic s, input logic e, input logic f,
                             input logic [SCORE_W-1:0] sc, input logic [COOR_W-1:0] x);
    int w = 0;
    while (!o_valid && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_vld"},   64'(o_valid), 64'd1);
    chk({tag, "_start"}, 64'(o_start), 64'(s));
    chk({tag, "_end"},   64'(o_end),   64'(e));
    chk({tag, "_flag"},  64'(o_flag),  64'(f));
    chk({tag, "_score"}, 64'(o_score), 64'(sc));
    chk({tag, "_x"},     64'(o_coor_x), 64'(x));
    chk({tag, "_y"},     64'(o_coor_y), f ? 64'(y_of(x)) : 64'd0);
    chk({tag, "_desc"},  64'(o_descriptor), f ? 64'(d_of(x)) : 64'd0);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_ready = 1'b0;
    clr_in();
    tick();
    tick();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_busy",  64'(o_busy),  64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_disc",  64'(o_discarded), 64'd0);
    chk("rst_score", 64'(o_score), 64'd0);
    chk("rst_drop",  64'(o_frame_drop), 64'd0);
    rst_n = 1'b1;
    tick();

    // Ordering, tie order and eviction with back-pressure in the middle of drain
    beat(1, 0, 0, 0, 0);
    beat(0, 0, 1, 10, 1);
    beat(0, 0, 1, 50, 2);
    beat(0, 0, 1, 30, 3);
    beat(0, 0, 1, 50, 4);
    beat(0, 0, 1, 20, 5);
    beat(0, 0, 1, 40, 6);
    chk("t1_count", 64'(o_count), 64'd4);
    chk("t1_disc",  64'(o_discarded), 64'd2);
    chk("t1_novld", 64'(o_valid), 64'd0);
    beat(0, 1, 0, 0, 0);
    chk("t1_busy",   64'(o_busy),  64'd1);
    chk("t1_dcount", 64'(o_count), 64'd4);
    expect_beat("t1_b0", 1, 0, 1, 50, 2);
    for (int i = 0; i < 3; i++) begin
      chk("t1_hold_vld",   64'(o_valid),  64'd1);
      chk("t1_hold_score", 64'(o_score),  64'd50);
      chk("t1_hold_x",     64'(o_coor_x), 64'd4);
      chk("t1_hold_count", 64'(o_count),  64'd3);
      tick();
    end
    expect_beat("t1_b1", 0, 0, 1, 50, 4);
    chk("t1_disc_drain", 64'(o_discarded), 64'd2);
    expect_beat("t1_b2", 0, 0, 1, 40, 6);
    expect_beat("t1_b3", 0, 1, 1, 30, 3);
    chk("t1_done_vld",   64'(o_valid), 64'd0);
    chk("t1_done_busy",  64'(o_busy),  64'd0);
    chk("t1_done_count", 64'(o_count), 64'd0);

    // Empty frame
    beat(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("t2_novld", 64'(o_valid), 64'd0);
    beat(0, 1, 0, 0, 0);
    expect_beat("t2_b0", 1, 1, 0, 0, 0);
    chk("t2_done_vld", 64'(o_valid), 64'd0);

    // Start during drain is dropped; the following frame in idle is normal
    beat(1, 0, 0, 0, 0);
    beat(0, 0, 1, 5, 1);
    beat(0, 0, 1, 9, 2);
    beat(0, 1, 0, 0, 0);
    beat(1, 0, 1, 250, 30);
    chk("t3_drop",    64'(o_frame_drop), 64'd1);
    chk("t3_dcount",  64'(o_count), 64'd2);
    chk("t3_dscore",  64'(o_score), 64'd9);
    tick();
    chk("t3_drop_off", 64'(o_frame_drop), 64'd0);
    beat(0, 0, 1, 251, 31);
    expect_beat("t3_b0", 1, 0, 1, 9, 2);
    expect_beat("t3_b1", 0, 1, 1, 5, 1);
    beat(0, 1, 1, 252, 32);
    chk("t3_idle_vld", 64'(o_valid), 64'd0);
    beat(1, 0, 1, 77, 40);
    beat(0, 1, 0, 0, 0);
    expect_beat("t3_b2", 1, 1, 1, 77, 40);

    // Mid-frame reset discards the partial frame
    beat(1, 0, 0, 0, 0);
    beat(0, 0, 1, 100, 7);
    beat(0, 0, 1, 101, 8);
    beat(0, 0, 1, 102, 9);
    chk("t4_count", 64'(o_count), 64'd3);
    rst_n = 1'b0;
    tick();
    chk("t4_rst_count", 64'(o_count), 64'd0);
    chk("t4_rst_vld",   64'(o_valid), 64'd0);
    chk("t4_rst_busy",  64'(o_busy),  64'd0);
    chk("t4_rst_score", 64'(o_score), 64'd0);
    rst_n = 1'b1;
    tick();
    beat(1, 0, 0, 0, 0);
    beat(0, 0, 1, 7, 21);
    beat(0, 1, 0, 0, 0);
    chk("t4_dcount", 64'(o_count), 64'd1);
    expect_beat("t4_b0", 1, 1, 1, 7, 21);

    // Restart in collect, flags on start and end cycles
    beat(1, 0, 1, 90, 50);
    beat(0, 0, 1, 91, 51);
    chk("t5_count_pre", 64'(o_count), 64'd2);
    beat(1, 0, 1, 200, 11);
    chk("t5_count_rst", 64'(o_count), 64'd1);
    chk("t5_novld",     64'(o_valid), 64'd0);
    beat(0, 0, 1, 150, 12);
    beat(0, 1, 1, 199, 13);
    chk("t5_dcount", 64'(o_count), 64'd3);
    expect_beat("t5_b0", 1, 0, 1, 200, 11);
    expect_beat("t5_b1", 0, 0, 1, 199, 13);
    expect_beat("t5_b2", 0, 1, 1, 150, 12);

    // Full table: equal-to-lowest is discarded, higher evicts the tail
    beat(1, 0, 1, 8, 1);
    beat(0, 0, 1, 8, 2);
    beat(0, 0, 1, 8, 3);
    beat(0, 0, 1, 8, 4);
    beat(0, 0, 1, 8, 5);
    chk("t6_disc_eq", 64'(o_discarded), 64'd1);
    beat(0, 0, 1, 9, 6);
    chk("t6_count", 64'(o_count), 64'd4);
    chk("t6_disc",  64'(o_discarded), 64'd2);
    beat(0, 1, 0, 0, 0);
    expect_beat("t6_b0", 1, 0, 1, 9, 6);
    expect_beat("t6_b1", 0, 0, 1, 8, 1);
    expect_beat("t6_b2", 0, 0, 1, 8, 2);
    expect_beat("t6_b3", 0, 1, 1, 8, 3);
    chk("t6_done_vld", 64'(o_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
